// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl
// Tag/valid keeper and block-fill sequencer for a direct-mapped instruction cache.
// Lookups hit in the same cycle. A miss fetches one block from DRAM a word at a time,
// then writes the assembled block to the data SRAM in a single cycle.
//
// Handshake semantics:
//   mem_req is raised in REQ with mem_addr stable and is held until the first cycle
//   mem_gnt=1; that cycle completes the request.
//   mem_rvalid qualifies mem_rdata only in FILL (words arrive in ascending order), and
//   there is no back-pressure on returned words. mem_rvalid outside FILL is ignored,
//   including on the grant cycle.
//   fetch_valid/stall: the fetch stage must hold fetch_addr while stall=1. Data is valid
//   only when fetch_hit=1.
module icache_fill_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,   // power of 2, at least 2
    parameter int INDEX_W     = 4
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                fetch_valid,
    input  logic [ADDR_W-1:0]                   fetch_addr,
    input  logic                                flush,
    output logic                                fetch_hit,
    output logic [WORD_W-1:0]                   fetch_inst,
    output logic                                stall,
    output logic                                mem_req,
    output logic [ADDR_W-1:0]                   mem_addr,
    input  logic                                mem_gnt,
    input  logic                                mem_rvalid,
    input  logic [WORD_W-1:0]                   mem_rdata,
    output logic                                sram_we,
    output logic [INDEX_W-1:0]                  sram_index,
    output logic [BLOCK_WORDS-1:0][WORD_W-1:0]  sram_wdata,
    input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  sram_rdata,
    output logic [1:0]                          dbg_state
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = CNT_W + 2;
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
    localparam int LINES = 1 << INDEX_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                              state_q;
    state_t                              state_d;
    logic [LINES-1:0]                    valid_q;
    logic [TAG_W-1:0]                    tag_q [LINES];
    logic [CNT_W-1:0]                    cnt_q;
    logic                                flush_pend_q;
    logic                                mem_req_q;
    logic [ADDR_W-1:0]                   mem_addr_q;
    logic                                sram_we_q;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0]  wdata_q;

    // Address fields of the live fetch and of the latched miss.
    logic [TAG_W-1:0]   f_tag;
    logic [INDEX_W-1:0] f_idx;
    logic [CNT_W-1:0]   f_word;
    logic [TAG_W-1:0]   m_tag;
    logic [INDEX_W-1:0] m_idx;
    logic               unused_addr_bits;

    assign f_tag  = fetch_addr[ADDR_W-1 -: TAG_W];
    assign f_idx  = fetch_addr[OFF_W +: INDEX_W];
    assign f_word = fetch_addr[2 +: CNT_W];
    assign m_tag  = mem_addr_q[ADDR_W-1 -: TAG_W];
    assign m_idx  = mem_addr_q[OFF_W +: INDEX_W];
    assign unused_addr_bits = ^fetch_addr[1:0];

    // Control strobes derived from the current state and inputs.
    logic hit;
    logic start_miss;
    logic grant;
    logic fill_beat;
    logic last_beat;
    logic in_write;

    assign hit        = fetch_valid & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
    assign start_miss = (state_q == IDLE) & fetch_valid & ~hit;
    assign grant      = (state_q == REQ) & mem_gnt;
    assign fill_beat  = (state_q == FILL) & mem_rvalid;
    assign last_beat  = fill_beat & (cnt_q == LAST_BEAT);
    assign in_write   = (state_q == WRITE);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and lookup-side outputs.
    always_comb begin
        state_d    = state_q;
        fetch_hit  = 1'b0;
        stall      = 1'b1;
        sram_index = m_idx;
        fetch_inst = sram_rdata[f_word];
        unique case (state_q)
            IDLE: begin
                sram_index = f_idx;
                fetch_hit  = hit;
                stall      = fetch_valid & ~hit;
                if (start_miss) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (last_beat) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // DRAM request: latch the block-aligned miss address, hold the request until granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else if (start_miss) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {fetch_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end else if (grant) begin
            mem_req_q  <= 1'b0;
        end
    end

    // Beat counter and block assembly buffer; only beats seen in FILL are captured.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            cnt_q   <= '0;
        end else if (fill_beat) begin
            wdata_q[cnt_q] <= mem_rdata;
            cnt_q          <= cnt_q + CNT_W'(1);
        end
    end

    // SRAM write strobe: one cycle, coincident with the WRITE state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sram_we_q <= 1'b0;
        end else begin
            sram_we_q <= last_beat;
        end
    end

    // Valid bits and deferred flush; a flush seen while busy wins over the line install.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (flush) begin
                valid_q <= '0;
            end
        end else if (in_write) begin
            flush_pend_q <= 1'b0;
            if (flush_pend_q | flush) begin
                valid_q <= '0;
            end else begin
                valid_q[m_idx] <= 1'b1;
            end
        end else if (flush) begin
            flush_pend_q <= 1'b1;
        end
    end

    // Tag array is never reset; an entry is only trusted when its valid bit is set.
    always_ff @(posedge clock) begin
        if (in_write) begin
            tag_q[m_idx] <= m_tag;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign sram_we    = sram_we_q;
    assign sram_wdata = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl. Acts as fetch stage, DRAM and data SRAM.
module tb_icache_fill_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic                  clock;
    logic                  reset_n;
    logic                  fetch_valid;
    logic [31:0]           fetch_addr;
    logic                  flush;
    logic                  fetch_hit;
    logic [31:0]           fetch_inst;
    logic                  stall;
    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;
    logic                  sram_we;
    logic [3:0]            sram_index;
    logic [3:0][31:0]      sram_wdata;
    logic [3:0][31:0]      sram_rdata;
    logic [1:0]            dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    icache_fill_ctrl #(
        .ADDR_W(32), .WORD_W(32), .BLOCK_WORDS(4), .INDEX_W(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .flush(flush),
        .fetch_hit(fetch_hit), .fetch_inst(fetch_inst), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .sram_we(sram_we), .sram_index(sram_index),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Data SRAM model: synchronous write, combinational read.
    logic [3:0][31:0] sram_mem [16];
    always @(posedge clock) begin
        if (sram_we) sram_mem[sram_index] <= sram_wdata;
    end
    assign sram_rdata = sram_mem[sram_index];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one block fill starting from the REQ state. Optional grant delay (during which
    // fetch_addr is perturbed), idle gaps between beats, and a flush pulse on a chosen beat.
    task automatic run_fill(input logic [31:0] exp_addr, input logic [3:0] exp_idx,
                            input logic [3:0][31:0] blk, input int gnt_wait,
                            input int gap, input int flush_beat);
        logic [31:0] saved;
        saved = fetch_addr;
        check_eq("req_state", dbg_state, S_REQ);
        check_eq("req", mem_req, 1'b1);
        check_eq("req_addr", mem_addr, exp_addr);
        for (int i = 0; i < gnt_wait; i++) begin
            fetch_addr = 32'h0000_0F00 + 32'(i * 16);
            step();
            check_eq("req_hold", mem_req, 1'b1);
            check_eq("addr_hold", mem_addr, exp_addr);
        end
        fetch_addr = saved;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check_eq("gnt_drop", mem_req, 1'b0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                step();
                check_eq("gap_state", dbg_state, S_FILL);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = blk[b];
            if (b == flush_beat) flush = 1'b1;
            step();
            mem_rvalid = 1'b0;
            flush      = 1'b0;
        end
        check_eq("we", sram_we, 1'b1);
        check_eq("we_state", dbg_state, S_WRITE);
        check_eq("we_index", sram_index, exp_idx);
        check_eq("wdata", sram_wdata, blk);
        check_eq("we_stall", stall, 1'b1);
        step();
        check_eq("we_pulse", sram_we, 1'b0);
        check_eq("back_idle", dbg_state, S_IDLE);
    endtask

    logic [3:0][31:0] blk_a;
    logic [3:0][31:0] blk_b;
    logic [3:0][31:0] blk_c;

    initial begin
        for (int i = 0; i < 16; i++) sram_mem[i] = '0;
        blk_a = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        blk_b = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
        blk_c = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};

        reset_n = 1'b0; fetch_valid = 1'b0; fetch_addr = '0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2;
        check_eq("rst_state", dbg_state, S_IDLE);
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_we", sram_we, 1'b0);
        check_eq("rst_wdata", sram_wdata, 128'h0);
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_hit", fetch_hit, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Cold miss on 0x104, immediate grant, A1 afterwards.
        fetch_valid = 1'b1; fetch_addr = 32'h0000_0104;
        #1;
        check_eq("cold_stall", stall, 1'b1);
        check_eq("cold_hit", fetch_hit, 1'b0);
        step();
        run_fill(32'h0000_0100, 4'd0, blk_a, 0, 0, -1);
        check_eq("cold_after_hit", fetch_hit, 1'b1);
        check_eq("cold_after_inst", fetch_inst, 32'hA000_0001);
        check_eq("cold_after_stall", stall, 1'b0);

        // Hit on the same line, word 3.
        fetch_addr = 32'h0000_010C;
        #1;
        check_eq("hit_hit", fetch_hit, 1'b1);
        check_eq("hit_inst", fetch_inst, 32'hA000_0003);
        step();
        check_eq("hit_noreq", mem_req, 1'b0);
        check_eq("hit_state", dbg_state, S_IDLE);

        // Miss on another index with a 5-cycle grant delay and gaps between beats.
        fetch_addr = 32'h0000_0234;
        #1;
        check_eq("c_stall", stall, 1'b1);
        step();
        run_fill(32'h0000_0230, 4'd3, blk_c, 5, 2, -1);
        check_eq("c_hit", fetch_hit, 1'b1);
        check_eq("c_inst", fetch_inst, 32'hC000_0001);
        fetch_addr = 32'h0000_0108;
        #1;
        check_eq("a_still_hit", fetch_hit, 1'b1);
        check_eq("a_still_inst", fetch_inst, 32'hA000_0002);

        // Conflict: same index 0, tag 0x11.
        fetch_addr = 32'h0000_1108;
        #1;
        check_eq("conf_stall", stall, 1'b1);
        check_eq("conf_hit", fetch_hit, 1'b0);
        step();
        run_fill(32'h0000_1100, 4'd0, blk_b, 0, 0, -1);
        check_eq("conf_hit2", fetch_hit, 1'b1);
        check_eq("conf_inst", fetch_inst, 32'hB000_0002);
        fetch_addr = 32'h0000_0100;
        #1;
        check_eq("evict_stall", stall, 1'b1);
        check_eq("evict_hit", fetch_hit, 1'b0);
        fetch_valid = 1'b0;
        step();
        check_eq("evict_noreq", mem_req, 1'b0);

        // Flush in IDLE: hit still seen on the flush cycle, gone afterwards.
        fetch_valid = 1'b1; fetch_addr = 32'h0000_0234; flush = 1'b1;
        #1;
        check_eq("flush_same_hit", fetch_hit, 1'b1);
        step();
        flush = 1'b0;
        #1;
        check_eq("flush_c_stall", stall, 1'b1);
        check_eq("flush_c_hit", fetch_hit, 1'b0);
        fetch_addr = 32'h0000_1108;
        #1;
        check_eq("flush_b_hit", fetch_hit, 1'b0);

        // Flush during FILL: refilled line comes back invalid.
        fetch_addr = 32'h0000_0234;
        #1;
        step();
        run_fill(32'h0000_0230, 4'd3, blk_c, 0, 0, 2);
        check_eq("pend_stall", stall, 1'b1);
        check_eq("pend_hit", fetch_hit, 1'b0);
        step();
        run_fill(32'h0000_0230, 4'd3, blk_c, 1, 1, -1);
        check_eq("refill_hit", fetch_hit, 1'b1);
        check_eq("refill_inst", fetch_inst, 32'hC000_0001);

        // Reset mid-FILL after 2 beats.
        fetch_addr = 32'h0000_1108;
        #1;
        step();
        check_eq("mid_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1; mem_rdata = blk_b[b];
            step();
        end
        mem_rvalid = 1'b0;
        check_eq("mid_state", dbg_state, S_FILL);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_state", dbg_state, S_IDLE);
        check_eq("mid_rst_req", mem_req, 1'b0);
        check_eq("mid_rst_we", sram_we, 1'b0);
        check_eq("mid_rst_wdata", sram_wdata, 128'h0);
        step();
        reset_n = 1'b1;
        fetch_addr = 32'h0000_0234;
        #1;
        check_eq("mid_inval_stall", stall, 1'b1);
        check_eq("mid_inval_hit", fetch_hit, 1'b0);
        fetch_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
